// File: rtl/psum_rmw_ctrl.sv
// Read-modify-write accumulator in front of the 128-bit partial-sum SRAM.
// Each accepted row is added lane-wise (saturating, optional ReLU) to the stored row and written back.
module psum_rmw_ctrl #(
    parameter int col     = 8,
    parameter int psum_bw = 16,
    parameter int addr_bw = 11
) (
    input  logic                     CLK,
    input  logic                     reset_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [col*psum_bw-1:0]   in_data,
    input  logic [addr_bw-1:0]       in_addr,
    input  logic                     in_first,
    input  logic                     in_relu,
    output logic                     sram_cen,
    output logic                     sram_wen,
    output logic [addr_bw-1:0]       sram_a,
    output logic [col*psum_bw-1:0]   sram_d,
    input  logic [col*psum_bw-1:0]   sram_q,
    output logic                     busy,
    output logic [15:0]              wr_count
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RD   = 2'd1;
    localparam logic [1:0] WR   = 2'd2;

    logic [1:0]               state;
    logic [1:0]               state_nxt;
    logic [col*psum_bw-1:0]   hold_data;
    logic [addr_bw-1:0]       hold_addr;
    logic                     hold_first;
    logic                     hold_relu;
    logic [col*psum_bw-1:0]   d_last;
    logic [col*psum_bw-1:0]   result;
    logic                     accept;

    logic [psum_bw-1:0]       old_l;
    logic [psum_bw-1:0]       add_l;
    logic [psum_bw:0]         sum_l;
    logic [psum_bw-1:0]       lane_l;

    assign in_ready = (state != RD);
    assign accept   = in_valid && in_ready;
    assign busy     = (state != IDLE);
    assign sram_cen = (state == IDLE);
    assign sram_wen = (state != WR);
    assign sram_a   = hold_addr;
    // d_last keeps the write-data pins stable outside WR
    assign sram_d   = (state == WR) ? result : d_last;

    always_comb begin
        result = '0;
        old_l  = '0;
        add_l  = '0;
        sum_l  = '0;
        lane_l = '0;
        for (int unsigned i = 0; i < col; i++) begin
            old_l = hold_first ? '0 : sram_q[i*psum_bw +: psum_bw];
            add_l = hold_data[i*psum_bw +: psum_bw];
            sum_l = {old_l[psum_bw-1], old_l} + {add_l[psum_bw-1], add_l};
            // top two bits disagree only on signed overflow; saturate toward the true sign
            if (sum_l[psum_bw] != sum_l[psum_bw-1])
                lane_l = sum_l[psum_bw] ? {1'b1, {(psum_bw-1){1'b0}}}
                                        : {1'b0, {(psum_bw-1){1'b1}}};
            else
                lane_l = sum_l[psum_bw-1:0];
            if (hold_relu && lane_l[psum_bw-1])
                lane_l = '0;
            result[i*psum_bw +: psum_bw] = lane_l;
        end
    end

    always_comb begin
        state_nxt = IDLE;
        case (state)
            IDLE, WR: begin
                if (accept)
                    state_nxt = in_first ? WR : RD;
                else
                    state_nxt = IDLE;
            end
            RD:      state_nxt = WR;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            hold_data  <= '0;
            hold_addr  <= '0;
            hold_first <= 1'b0;
            hold_relu  <= 1'b0;
            d_last     <= '0;
            wr_count   <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                hold_data  <= in_data;
                hold_addr  <= in_addr;
                hold_first <= in_first;
                hold_relu  <= in_relu;
            end
            if (state == WR) begin
                d_last   <= result;
                wr_count <= wr_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_psum_rmw_ctrl.sv
// Bench for psum_rmw_ctrl: bench-side SRAM, transaction-level reference model,
// directed cases with literal expectations followed by randomized traffic.
module tb_psum_rmw_ctrl;

    localparam int COL = 8;
    localparam int PBW = 16;
    localparam int ABW = 11;
    localparam int W   = COL * PBW;

    logic           CLK = 1'b0;
    logic           reset_n;
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   in_data;
    logic [ABW-1:0] in_addr;
    logic           in_first;
    logic           in_relu;
    logic           sram_cen;
    logic           sram_wen;
    logic [ABW-1:0] sram_a;
    logic [W-1:0]   sram_d;
    logic [W-1:0]   sram_q;
    logic           busy;
    logic [15:0]    wr_count;

    always #5 CLK = ~CLK;

    psum_rmw_ctrl #(.col(COL), .psum_bw(PBW), .addr_bw(ABW)) dut (
        .CLK(CLK), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_addr(in_addr), .in_first(in_first), .in_relu(in_relu),
        .sram_cen(sram_cen), .sram_wen(sram_wen), .sram_a(sram_a),
        .sram_d(sram_d), .sram_q(sram_q), .busy(busy), .wr_count(wr_count)
    );

    // Bench-side SRAM: one-cycle read latency, write lands on the edge
    logic [W-1:0] mem [0:2047];
    initial begin
        for (int i = 0; i < 2048; i++) mem[i] = '0;
        sram_q = '0;
        forever begin
            @(posedge CLK);
            if (!sram_cen) begin
                if (!sram_wen) mem[sram_a] <= sram_d;
                else           sram_q      <= mem[sram_a];
            end
        end
    end

    int checks = 0;
    int failures = 0;

    // Reference model: memory contents plus the transaction currently in flight
    logic [W-1:0]   ref_mem [0:2047];
    int             phase;      // 0 nothing in flight, 1 read cycle, 2 write cycle
    logic [ABW-1:0] cur_addr;
    logic [W-1:0]   cur_d;
    logic [W-1:0]   cur_prev;
    logic [ABW-1:0] last_a;
    logic [W-1:0]   last_d;
    logic [15:0]    exp_count;

    function automatic logic [W-1:0] rmw(logic [W-1:0] old, logic [W-1:0] add, logic relu);
        logic [W-1:0] r;
        int s;
        r = '0;
        for (int i = 0; i < COL; i++) begin
            s = int'($signed(old[i*PBW +: PBW])) + int'($signed(add[i*PBW +: PBW]));
            if (s > 32767)  s = 32767;
            if (s < -32768) s = -32768;
            if (relu && s < 0) s = 0;
            r[i*PBW +: PBW] = s[15:0];
        end
        return r;
    endfunction

    function automatic logic [W-1:0] all_lanes(logic [PBW-1:0] v);
        logic [W-1:0] r;
        for (int i = 0; i < COL; i++) r[i*PBW +: PBW] = v;
        return r;
    endfunction

    task automatic chk(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic check_outputs();
        chk("in_ready", W'(in_ready), W'(phase != 1));
        chk("busy", W'(busy), W'(phase != 0));
        chk("sram_cen", W'(sram_cen), W'(phase == 0));
        chk("wr_count", W'(wr_count), W'(exp_count));
        if (phase == 0) begin
            chk("idle_sram_a", W'(sram_a), W'(last_a));
            chk("idle_sram_d", sram_d, last_d);
        end else begin
            chk("sram_wen", W'(sram_wen), W'(phase == 1));
            chk("sram_a", W'(sram_a), W'(cur_addr));
            if (phase == 2) chk("sram_d", sram_d, cur_d);
        end
    endtask

    // One clock cycle: check current outputs, present inputs, advance model at the edge
    task automatic step(input logic v, input logic [ABW-1:0] a, input logic [W-1:0] d,
                        input logic f, input logic r);
        logic acc;
        check_outputs();
        in_valid = v; in_addr = a; in_data = d; in_first = f; in_relu = r;
        acc = v && (phase != 1);
        @(posedge CLK);
        if (phase == 2) begin
            exp_count = exp_count + 16'd1;
            last_d = cur_d;
        end
        if (phase == 1) begin
            phase = 2;
        end else if (acc) begin
            cur_addr = a;
            last_a = a;
            cur_prev = ref_mem[a];
            cur_d = rmw(f ? '0 : cur_prev, d, r);
            ref_mem[a] = cur_d;
            phase = f ? 2 : 1;
        end else begin
            phase = 0;
        end
        @(negedge CLK);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, '0, 1'b0, 1'b0);
    endtask

    // Asynchronous reset pulse starting at a falling edge; in-flight write is dropped
    task automatic do_reset();
        reset_n = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("rst_cen", W'(sram_cen), W'(1));
        chk("rst_busy", W'(busy), W'(0));
        chk("rst_wr_count", W'(wr_count), W'(0));
        chk("rst_sram_a", W'(sram_a), W'(0));
        chk("rst_sram_d", sram_d, '0);
        if (phase != 0) ref_mem[cur_addr] = cur_prev;
        phase = 0; exp_count = '0; last_a = '0; last_d = '0;
        @(posedge CLK);
        @(negedge CLK);
        reset_n = 1'b1;
        #1;
        chk("rst_in_ready", W'(in_ready), W'(1));
        @(negedge CLK);
    endtask

    initial begin
        logic [W-1:0] d0, d1, ex;
        reset_n = 1'b0;
        in_valid = 1'b0; in_addr = '0; in_data = '0; in_first = 1'b0; in_relu = 1'b0;
        for (int i = 0; i < 2048; i++) ref_mem[i] = '0;
        phase = 0; cur_addr = '0; cur_d = '0; cur_prev = '0;
        last_a = '0; last_d = '0; exp_count = '0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        reset_n = 1'b1;
        @(negedge CLK);
        chk("init_ready", W'(in_ready), W'(1));
        chk("init_cen", W'(sram_cen), W'(1));
        chk("init_busy", W'(busy), W'(0));
        chk("init_sram_d", sram_d, '0);

        // First write of 5 to addr 3
        step(1'b1, 11'd3, all_lanes(16'd5), 1'b1, 1'b0);
        chk("first_wen", W'(sram_wen), W'(0));
        chk("first_a", W'(sram_a), W'(3));
        chk("first_d", sram_d, all_lanes(16'd5));
        idle(1);
        chk("first_count", W'(wr_count), W'(1));

        // Accumulate 7 onto addr 3
        step(1'b1, 11'd3, all_lanes(16'd7), 1'b0, 1'b0);
        chk("acc_rd_wen", W'(sram_wen), W'(1));
        chk("acc_rd_a", W'(sram_a), W'(3));
        idle(1);
        chk("acc_d", sram_d, all_lanes(16'd12));
        idle(1);
        chk("acc_count", W'(wr_count), W'(2));

        // Saturation on addr 4
        d0 = '0; d1 = all_lanes(16'd1); ex = '0;
        for (int i = 2; i < COL; i++) begin
            d0[i*PBW +: PBW] = 16'(100 * i);
            ex[i*PBW +: PBW] = 16'(100 * i + 1);
        end
        d0[15:0] = 16'h7FF0; d0[31:16] = 16'h8010;
        d1[15:0] = 16'h0020; d1[31:16] = 16'hFFC0;
        ex[15:0] = 16'h7FFF; ex[31:16] = 16'h8000;
        step(1'b1, 11'd4, d0, 1'b1, 1'b0);
        step(1'b1, 11'd4, d1, 1'b0, 1'b0);
        idle(1);
        chk("sat_d", sram_d, ex);
        idle(1);

        // ReLU on addr 5
        d0 = '0; d0[15:0] = 16'hFFFD; d0[31:16] = 16'd4;
        ex = all_lanes(16'd1); ex[15:0] = 16'd0; ex[31:16] = 16'd5;
        step(1'b1, 11'd5, d0, 1'b1, 1'b0);
        step(1'b1, 11'd5, all_lanes(16'd1), 1'b0, 1'b1);
        idle(1);
        chk("relu_d", sram_d, ex);
        idle(1);
        chk("relu_count", W'(wr_count), W'(6));

        // Reset during the read cycle of an accumulate to addr 7
        step(1'b1, 11'd7, all_lanes(16'h22), 1'b0, 1'b0);
        do_reset();
        idle(2);
        chk("dropped_not_written", mem[7], '0);

        // Back-to-back accumulates on addr 9 with in_valid held high
        step(1'b1, 11'd9, '0, 1'b1, 1'b0);
        for (int k = 0; k < 6; k++) begin
            chk("b2b_ready", W'(in_ready), W'(k % 2 == 0));
            if (k % 2 == 0 && k > 0) chk("b2b_d", sram_d, all_lanes(16'(k / 2)));
            step(1'b1, 11'd9, all_lanes(16'd1), 1'b0, 1'b0);
        end
        chk("b2b_last_d", sram_d, all_lanes(16'd3));
        idle(2);
        chk("b2b_count", W'(wr_count), W'(4));
        chk("b2b_mem", mem[9], all_lanes(16'd3));

        // Randomized traffic on a small address window to provoke hazards
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 399) == 0) begin
                do_reset();
            end else begin
                d0 = '0;
                for (int i = 0; i < COL; i++) begin
                    case ($urandom_range(0, 4))
                        3:       d0[i*PBW +: PBW] = 16'h7F00 | 16'($urandom_range(0, 255));
                        4:       d0[i*PBW +: PBW] = 16'h8000 | 16'($urandom_range(0, 255));
                        default: d0[i*PBW +: PBW] = 16'($urandom);
                    endcase
                end
                step($urandom_range(0, 9) < 7, 11'($urandom_range(0, 7)), d0,
                     $urandom_range(0, 9) < 3, $urandom_range(0, 3) == 0);
            end
        end
        idle(3);
        for (int i = 0; i < 16; i++) chk("final_mem", mem[i], ref_mem[i]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
